// File: rtl/ysyx_220066_mem_arbiter.sv
// Shared memory-bus arbiter for the fetch and data ports.
// Round-robin grant, one outstanding transaction, load/store lane shifting.
module ysyx_220066_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_flush,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  input  logic [2:0]  dm_op,
  output logic        dm_valid,
  output logic [63:0] dm_rdata,
  output logic        dm_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata,
  input  logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;

  logic          owner_dm, last_dm, dropped;
  logic [63:0]   addr_q, wdata_q;
  logic [2:0]    op_q;
  logic          we_q;
  logic [7:0]    wmask_q;
  logic [CW-1:0] cnt;

  logic       if_pend, dm_pend, grant, grant_dm, st;
  logic       dm_mis, if_mis, mis;
  logic [2:0] am;
  logic [7:0] st_mask;
  logic       rsp_done, tmo, done, cmp_err;
  logic [63:0] sh, ld;
  logic [31:0] ifd;

  // A requester still high during its own valid cycle is the old request.
  assign if_pend  = if_req & ~if_valid;
  assign dm_pend  = dm_req & ~dm_valid;
  assign grant    = (state == IDLE) & (if_pend | dm_pend);
  assign grant_dm = dm_pend & (~if_pend | ~last_dm);
  assign st       = grant_dm & dm_we;

  always_comb begin
    am      = 3'b000;
    st_mask = 8'h00;
    unique case (dm_op[1:0])
      2'd0: begin am = 3'b000; st_mask = 8'h01; end
      2'd1: begin am = 3'b001; st_mask = 8'h03; end
      2'd2: begin am = 3'b011; st_mask = 8'h0f; end
      2'd3: begin am = 3'b111; st_mask = 8'hff; end
    endcase
  end

  assign dm_mis = (dm_op == 3'b111) | ((dm_addr[2:0] & am) != 3'b000);
  assign if_mis = if_addr[1:0] != 2'b00;
  assign mis    = grant_dm ? dm_mis : if_mis;

  always_comb begin
    state_nx = state;
    rsp_done = 1'b0;
    unique case (state)
      IDLE: if (grant && !mis) state_nx = REQ;
      REQ: begin
        if (bus_ready && bus_rvalid) begin
          rsp_done = 1'b1;
          state_nx = IDLE;
        end else if (bus_ready) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          rsp_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    tmo = (state != IDLE) & ~rsp_done & (cnt == CW'(TIMEOUT - 1));
    if (tmo) state_nx = IDLE;
  end

  assign done    = rsp_done | tmo;
  assign cmp_err = tmo | bus_err;

  always_comb begin
    sh = bus_rdata >> {addr_q[2:0], 3'b000};
    case (op_q)
      3'b000:  ld = {{56{sh[7]}}, sh[7:0]};
      3'b001:  ld = {{48{sh[15]}}, sh[15:0]};
      3'b010:  ld = {{32{sh[31]}}, sh[31:0]};
      3'b100:  ld = {56'd0, sh[7:0]};
      3'b101:  ld = {48'd0, sh[15:0]};
      3'b110:  ld = {32'd0, sh[31:0]};
      default: ld = sh;
    endcase
  end

  assign ifd = addr_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner_dm <= 1'b0;
      last_dm  <= 1'b0;
      dropped  <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= '0;
      we_q     <= 1'b0;
      wmask_q  <= '0;
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      dm_valid <= 1'b0;
      dm_err   <= 1'b0;
      dm_rdata <= '0;
    end else begin
      state    <= state_nx;
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      dm_valid <= 1'b0;
      dm_err   <= 1'b0;
      dm_rdata <= '0;
      if (state != IDLE) cnt <= cnt + 1'b1;
      if (state != IDLE && !owner_dm && if_flush) dropped <= 1'b1;
      if (grant) begin
        owner_dm <= grant_dm;
        last_dm  <= grant_dm;
        dropped  <= 1'b0;
        cnt      <= '0;
        addr_q   <= grant_dm ? dm_addr : if_addr;
        op_q     <= grant_dm ? dm_op : 3'b010;
        we_q     <= st;
        wdata_q  <= st ? dm_wdata << {dm_addr[2:0], 3'b000} : '0;
        wmask_q  <= st ? st_mask << dm_addr[2:0] : '0;
        if (mis && grant_dm) begin
          dm_valid <= 1'b1;
          dm_err   <= 1'b1;
        end else if (mis) begin
          if_valid <= 1'b1;
          if_err   <= 1'b1;
        end
      end
      if (done && owner_dm) begin
        dm_valid <= 1'b1;
        dm_err   <= cmp_err;
        dm_rdata <= rsp_done ? ld : '0;
      end else if (done && !dropped && !if_flush) begin
        if_valid <= 1'b1;
        if_err   <= cmp_err;
        if_rdata <= rsp_done ? ifd : '0;
      end
    end
  end

  assign bus_req   = (state == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[63:3], 3'b000};
  assign bus_wdata = wdata_q;
  assign bus_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_220066_mem_arbiter.sv
// Directed and randomized bench for the memory arbiter.
// The bench plays the bus slave and predicts each completion.
module tb_ysyx_220066_mem_arbiter;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_valid, if_err;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [63:0] dm_addr = '0, dm_wdata = '0;
  logic [2:0]  dm_op = '0;
  logic        dm_valid, dm_err;
  logic [63:0] dm_rdata;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [63:0] bus_rdata = '0;

  int total = 0, passed = 0, failed = 0;

  ysyx_220066_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_op(dm_op),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{if_valid, if_err, if_rdata, dm_valid, dm_err, dm_rdata,
             bus_req, bus_we, bus_addr, bus_wdata, bus_wmask};
  endfunction

  // Reference: byte lane extraction and extension from the MemOp rules.
  function automatic logic [63:0] exp_load(input logic [2:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] d);
    int n;
    logic [63:0] v, m;
    n = 1 << op[1:0];
    v = d >> (8 * (a % 8));
    if (n == 8) return v;
    m = (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (op < 3'd3 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  task automatic set_dm(input logic we, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] wd);
    dm_req = 1'b1; dm_we = we; dm_op = op; dm_addr = a; dm_wdata = wd;
  endtask

  task automatic set_if(input logic [63:0] a);
    if_req = 1'b1; if_addr = a;
  endtask

  // Called one step after the grant edge; returns just after completion.
  task automatic respond(input int lr, input int lv, input logic [63:0] ea,
                         input logic [63:0] d, input logic e);
    for (int i = 0; i < lr; i++) begin
      tick();
      chk("hold_req", 64'(bus_req), 64'd1);
      chk("hold_addr", bus_addr, ea);
    end
    bus_ready = 1'b1; bus_rdata = d; bus_err = e;
    bus_rvalid = (lv == 0);
    tick();
    bus_ready = 1'b0;
    if (lv > 0) begin
      bus_rvalid = 1'b0;
      chk("resp_drop", 64'(bus_req), 64'd0);
      for (int i = 1; i < lv; i++) tick();
      bus_rvalid = 1'b1;
      tick();
    end
    bus_rvalid = 1'b0; bus_err = 1'b0;
  endtask

  task automatic run_one();
    logic is_dm, we, mis, berr;
    logic [2:0] op;
    logic [63:0] a, wd, d, ea;
    int n, off, lr, lv;
    is_dm = 1'($urandom_range(0, 1));
    op = 3'($urandom_range(0, 6));
    if ($urandom_range(0, 15) == 0) op = 3'd7;
    we = is_dm && op <= 3'd3 && ($urandom_range(0, 1) == 1);
    n = is_dm ? (1 << op[1:0]) : 4;
    a = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) a = a - (a % n);
    off = int'(a % 8);
    mis = is_dm ? (op == 3'd7 || (a % n) != 0) : ((a % 4) != 0);
    wd = {$urandom, $urandom};
    ea = a - (a % 8);
    if (is_dm) set_dm(we, op, a, wd);
    else set_if(a);
    tick();
    if (mis) begin
      chk("r_mis_busreq", 64'(bus_req), 64'd0);
      chk("r_mis_valid", 64'(is_dm ? dm_valid : if_valid), 64'd1);
      chk("r_mis_err", 64'(is_dm ? dm_err : if_err), 64'd1);
      chk("r_mis_rdata", is_dm ? dm_rdata : 64'(if_rdata), 64'd0);
    end else begin
      chk("r_busreq", 64'(bus_req), 64'd1);
      chk("r_addr", bus_addr, ea);
      if (is_dm) chk("r_we", 64'(bus_we), 64'(we));
      if (we) begin
        chk("r_wmask", 64'(bus_wmask),
            64'((((1 << n) - 1) << off) & 255));
        chk("r_wdata", bus_wdata, wd << (8 * off));
      end
      d = {$urandom, $urandom};
      berr = ($urandom_range(0, 7) == 0);
      lr = $urandom_range(0, 3);
      lv = $urandom_range(0, 3);
      respond(lr, lv, ea, d, berr);
      chk("r_valid", 64'(is_dm ? dm_valid : if_valid), 64'd1);
      chk("r_err", 64'(is_dm ? dm_err : if_err), 64'(berr));
      if (!berr && is_dm && !we)
        chk("r_ld", dm_rdata, exp_load(op, a, d));
      if (!berr && !is_dm)
        chk("r_if", 64'(if_rdata),
            (d >> (32 * ((a / 4) % 2))) & 64'hFFFF_FFFF);
    end
    dm_req = 1'b0; if_req = 1'b0;
    tick();
    chk("r_pulse_end", 64'(is_dm ? dm_valid : if_valid), 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_outs", 64'(any_out()), 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_outs", 64'(any_out()), 64'd0);

    set_if(64'h8000_0004);
    tick();
    chk("if_busreq", 64'(bus_req), 64'd1);
    chk("if_addr", bus_addr, 64'h8000_0000);
    respond(0, 2, 64'h8000_0000, 64'h11112222_33334444, 1'b0);
    chk("if_valid", 64'(if_valid), 64'd1);
    chk("if_rdata", 64'(if_rdata), 64'h1111_2222);
    chk("if_err", 64'(if_err), 64'd0);
    if_req = 1'b0;
    tick();
    chk("if_pulse", 64'(if_valid), 64'd0);

    set_dm(1'b0, 3'b011, 64'h1000, 64'd0);
    set_if(64'h2000);
    tick();
    chk("arb_dm1", bus_addr, 64'h1000);
    respond(0, 0, 64'h1000, 64'h0123_4567_89ab_cdef, 1'b0);
    chk("arb_dm1_v", 64'(dm_valid), 64'd1);
    chk("arb_dm1_d", dm_rdata, 64'h0123_4567_89ab_cdef);
    tick();
    chk("arb_if", bus_addr, 64'h2000);
    respond(0, 0, 64'h2000, 64'h5555_6666_7777_8888, 1'b0);
    chk("arb_if_v", 64'(if_valid), 64'd1);
    tick();
    chk("arb_dm2", bus_addr, 64'h1000);
    if_req = 1'b0;
    respond(1, 0, 64'h1000, 64'd0, 1'b0);
    chk("arb_dm2_v", 64'(dm_valid), 64'd1);
    dm_req = 1'b0;
    tick();

    set_dm(1'b0, 3'b000, 64'h8000_0003, 64'd0);
    tick();
    respond(1, 1, 64'h8000_0000, 64'h0000_0000_8000_0000, 1'b0);
    chk("lb", dm_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    dm_req = 1'b0;
    tick();
    set_dm(1'b0, 3'b100, 64'h8000_0003, 64'd0);
    tick();
    respond(0, 1, 64'h8000_0000, 64'h0000_0000_8000_0000, 1'b0);
    chk("lbu", dm_rdata, 64'h80);
    dm_req = 1'b0;
    tick();
    set_dm(1'b1, 3'b001, 64'h8000_0006, 64'hABCD);
    tick();
    chk("sh_we", 64'(bus_we), 64'd1);
    chk("sh_mask", 64'(bus_wmask), 64'hC0);
    chk("sh_data", 64'(bus_wdata[63:48]), 64'hABCD);
    respond(0, 0, 64'h8000_0000, 64'd0, 1'b0);
    chk("sh_valid", 64'(dm_valid), 64'd1);
    dm_req = 1'b0;
    tick();

    set_dm(1'b0, 3'b010, 64'h8000_0002, 64'd0);
    tick();
    chk("mis_valid", 64'(dm_valid), 64'd1);
    chk("mis_err", 64'(dm_err), 64'd1);
    chk("mis_rdata", dm_rdata, 64'd0);
    chk("mis_busreq", 64'(bus_req), 64'd0);
    dm_req = 1'b0;
    tick();
    chk("mis_busreq2", 64'(bus_req), 64'd0);

    set_dm(1'b0, 3'b011, 64'h3000, 64'd0);
    tick();
    repeat (TMO - 1) tick();
    chk("tmo_early", 64'(dm_valid), 64'd0);
    chk("tmo_req", 64'(bus_req), 64'd1);
    tick();
    chk("tmo_valid", 64'(dm_valid), 64'd1);
    chk("tmo_err", 64'(dm_err), 64'd1);
    dm_req = 1'b0;
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    chk("tmo_late", 64'(dm_valid), 64'd0);

    set_dm(1'b0, 3'b011, 64'h3008, 64'd0);
    tick();
    respond(0, 1, 64'h3008, 64'hFEED, 1'b1);
    chk("berr_valid", 64'(dm_valid), 64'd1);
    chk("berr_err", 64'(dm_err), 64'd1);
    dm_req = 1'b0;
    tick();

    set_if(64'h4000);
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; if_req = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h1234;
    tick();
    bus_rvalid = 1'b0;
    chk("flush_resp", 64'(if_valid), 64'd0);

    set_if(64'h4010);
    tick();
    if_flush = 1'b1; bus_ready = 1'b1; bus_rvalid = 1'b1;
    tick();
    if_flush = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    if_req = 1'b0;
    chk("flush_done", 64'(if_valid), 64'd0);

    if_flush = 1'b1;
    set_if(64'h4020);
    tick();
    if_flush = 1'b0;
    chk("flush_idle_req", 64'(bus_req), 64'd1);
    respond(0, 0, 64'h4020, 64'hDEADBEEF_CAFEF00D, 1'b0);
    chk("flush_idle_v", 64'(if_valid), 64'd1);
    chk("flush_idle_d", 64'(if_rdata), 64'hCAFE_F00D);
    if_req = 1'b0;
    tick();

    set_dm(1'b0, 3'b011, 64'h5000, 64'd0);
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_mid", 64'(any_out()), 64'd0);
    rst = 1'b1; dm_req = 1'b0;
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    chk("rst_late_dm", 64'(dm_valid), 64'd0);
    chk("rst_late_if", 64'(if_valid), 64'd0);

    set_dm(1'b0, 3'b011, 64'h6000, 64'd0);
    set_if(64'h7000);
    tick();
    chk("rst_prio_dm", bus_addr, 64'h6000);
    respond(0, 0, 64'h6000, 64'd0, 1'b0);
    dm_req = 1'b0;
    tick();
    chk("rst_prio_if", bus_addr, 64'h7000);
    respond(0, 0, 64'h7000, 64'd0, 1'b0);
    if_req = 1'b0;
    tick();

    for (int k = 0; k < 60; k++) run_one();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_220066_mem_arbiter.md
YSYX_220066_MEM_ARBITER -- requirements
Module: ysyx_220066_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waiting for a bus response before an error completion.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: if_req in 1 fetch request; if_addr in 64 fetch pc; if_flush in 1 discard in-flight fetch.
REQ-004 SHALL have ports: if_valid out 1 fetch done; if_rdata out 32 instruction; if_err out 1 fetch error.
REQ-005 SHALL have ports: dm_req in 1 data request; dm_we in 1 write; dm_addr in 64; dm_wdata in 64; dm_op in 3 MemOp (000 lb/sb, 001 lh/sh, 010 lw/sw, 011 ld/sd, 100 lbu, 101 lhu, 110 lwu).
REQ-006 SHALL have ports: dm_valid out 1 data done; dm_rdata out 64 extended load data; dm_err out 1 data error.
REQ-007 SHALL have ports: bus_req out 1; bus_we out 1; bus_addr out 64 (8-byte aligned); bus_wdata out 64; bus_wmask out 8.
REQ-008 SHALL have ports: bus_ready in 1 request accepted; bus_rvalid in 1 response; bus_rdata in 64; bus_err in 1.

Function
REQ-009 SHALL use a 3-state FSM: IDLE, REQ (bus_req=1, waiting for bus_ready), RESP (waiting for bus_rvalid).
REQ-010 In IDLE with a request pending, SHALL grant, latch owner/addr/op/wdata/we, and enter REQ next cycle; bus_req asserts the cycle after the request is seen.
REQ-011 SHALL arbitrate round-robin: when both requests are pending, grant the requester not served last; after reset, DM wins first.
REQ-012 bus_addr, bus_we, bus_wdata and bus_wmask SHALL be driven from the latched values and SHALL stay stable while bus_req=1.
REQ-013 In REQ, bus_ready=1 SHALL move to RESP and drop bus_req the next cycle; a same-cycle bus_rvalid SHALL complete directly to IDLE.
REQ-014 In RESP, bus_rvalid=1 SHALL produce a one-cycle completion pulse (if_valid or dm_valid) next cycle and return to IDLE.
REQ-015 Completion error flag SHALL equal bus_err, or 1 on timeout.
REQ-016 Requesters SHALL hold req and operands stable until their valid pulse; the arbiter SHALL treat a req still high in the cycle after its own valid as a new request.
REQ-017 if_rdata SHALL be bus_rdata[63:32] when addr[2]=1, else bus_rdata[31:0].
REQ-018 Loads SHALL shift bus_rdata right by 8*addr[2:0], then sign-extend (000/001/010) or zero-extend (100/101/110) to 64 bits; 011 passes 64 bits unchanged.
REQ-019 Stores SHALL set bus_wdata = dm_wdata << 8*addr[2:0] and bus_wmask = (1/3/F/FF for sb/sh/sw/sd) << addr[2:0].
REQ-020 Misalignment (IF: addr[1:0]!=0; DM: address not a multiple of the access size; dm_op=111) SHALL skip the bus, pulse the err+valid pair one cycle after grant, and leave rdata=0.
REQ-021 A cycle counter SHALL clear on entering REQ and increment in REQ/RESP; reaching TIMEOUT SHALL complete with err=1, return to IDLE, and ignore any later bus_rvalid for that transaction.
REQ-022 if_flush while IF owns the bus SHALL mark the transaction dropped: the bus handshake still finishes, but if_valid is suppressed; if_flush in IDLE SHALL have no effect.
REQ-023 if_flush coinciding with IF completion SHALL suppress that if_valid.
REQ-024 Only one transaction SHALL be outstanding at any time; a new grant is never issued from REQ or RESP.

Reset
REQ-025 rst=0 at a clock edge SHALL force IDLE, clear counter, dropped flag and last-grant (DM priority), and drive all outputs to 0, including mid-transaction; a response arriving after reset is ignored.

Verification
REQ-026 IF-only: if_addr=0x80000004, bus_rdata=0x11112222_33334444 with 2-cycle latency -> if_valid pulse, if_rdata=0x11112222, if_err=0.
REQ-027 Simultaneous if_req+dm_req after reset -> DM granted first, IF second; with both held, grants alternate DM, IF, DM.
REQ-028 lb at addr 0x...3, bus_rdata byte3=0x80 -> dm_rdata=0xFFFFFFFFFFFFFF80; same with lbu -> 0x80; sh at 0x...6 with data 0xABCD -> wmask=0xC0, wdata[63:48]=0xABCD.
REQ-029 Misaligned: lw at 0x...2 -> dm_valid+dm_err one cycle after grant, bus_req never asserted.
REQ-030 No bus_rvalid for TIMEOUT cycles -> err completion to the owner; bus_err=1 response -> err=1.
REQ-031 if_flush during RESP -> no if_valid; rst=0 during RESP -> all outputs 0 next cycle, late bus_rvalid ignored.
